// File: rtl/mpadder_modsched_if.sv
// Signal bundle between the modular add/sub scheduler, its two requesters and the shared adder.
// The master side is the environment (requesters plus adder); the slave side is the scheduler.
interface mpadder_modsched_if #(
  parameter int N = 1027
);
  logic [N-1:0] modulus;
  logic         req0;
  logic         req1;
  logic         op0;
  logic         op1;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic         done0;
  logic         done1;
  logic [N-1:0] result;
  logic         busy;
  logic         grant;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_sub;
  logic [N:0]   add_result;

  modport master (
    output modulus, req0, req1, op0, op1, a0, b0, a1, b1, add_result,
    input  done0, done1, result, busy, grant, add_a, add_b, add_sub
  );

  modport slave (
    input  modulus, req0, req1, op0, op1, a0, b0, a1, b1, add_result,
    output done0, done1, result, busy, grant, add_a, add_b, add_sub
  );
endinterface

// File: rtl/mpadder_modsched.sv
// Round-robin scheduler sharing one N-bit adder between two modular add/sub requesters.
// Each request takes one adder pass plus an optional modulus-correction pass.
module mpadder_modsched #(
  parameter int N         = 1027,
  parameter int ADDER_LAT = 1
) (
  input logic              clk,
  input logic              resetn,
  mpadder_modsched_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
  localparam logic [1:0] PASS2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int            CW       = $clog2(ADDER_LAT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ADDER_LAT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic          op_q, op_d;
  logic          sCarry_q, sCarry_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  addA_q, addA_d;
  logic [N-1:0]  addB_q, addB_d;
  logic          addSub_q, addSub_d;
  logic          sel;
  logic          lastCnt;

  assign lastCnt = (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    sCarry_d = sCarry_q;
    result_d = result_q;
    addA_d   = addA_q;
    addB_d   = addB_q;
    addSub_d = addSub_q;
    sel      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel      = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
          grant_d  = sel;
          op_d     = sel ? bus.op1 : bus.op0;
          addA_d   = sel ? bus.a1 : bus.a0;
          addB_d   = sel ? bus.b1 : bus.b0;
          addSub_d = sel ? bus.op1 : bus.op0;
          cnt_d    = '0;
          state_d  = PASS1;
        end
      end

      PASS1: begin
        if (!lastCnt) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d    = '0;
          sCarry_d = bus.add_result[N];
          if (op_q && !bus.add_result[N]) begin
            result_d = bus.add_result[N-1:0];
            state_d  = DONE;
          end else begin
            // Add tries s-M; a borrowed subtract adds M back.
            addA_d   = bus.add_result[N-1:0];
            addB_d   = bus.modulus;
            addSub_d = !op_q;
            state_d  = PASS2;
          end
        end
      end

      PASS2: begin
        if (!lastCnt) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = DONE;
          // addA_q still holds s[N-1:0], so it doubles as the uncorrected sum.
          if (op_q || sCarry_q || !bus.add_result[N]) begin
            result_d = bus.add_result[N-1:0];
          end else begin
            result_d = addA_q;
          end
        end
      end

      DONE: begin
        ptr_d   = !grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      ptr_q    <= 1'b0;
      op_q     <= 1'b0;
      sCarry_q <= 1'b0;
      result_q <= '0;
      addA_q   <= '0;
      addB_q   <= '0;
      addSub_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      sCarry_q <= sCarry_d;
      result_q <= result_d;
      addA_q   <= addA_d;
      addB_q   <= addB_d;
      addSub_q <= addSub_d;
    end
  end

  assign bus.done0   = (state_q == DONE) && !grant_q;
  assign bus.done1   = (state_q == DONE) && grant_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.grant   = grant_q;
  assign bus.result  = result_q;
  assign bus.add_a   = addA_q;
  assign bus.add_b   = addB_q;
  assign bus.add_sub = addSub_q;

endmodule

// File: tb/tb_mpadder_modsched.sv
// Scoreboard bench for mpadder_modsched: an 8-bit instance (latency 1) under directed and
// random traffic, plus a 1027-bit instance (latency 2) with a few wide operations.
module tb_mpadder_modsched;

  localparam int NW = 1027;

  typedef struct {
    logic [7:0] res;
    int         issueCyc;
    int         lat;
  } exp8_t;

  typedef struct {
    logic [NW-1:0] res;
    int            issueCyc;
    int            lat;
  } expW_t;

  logic  clk;
  logic  resetn;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  exp8_t q0[$];
  exp8_t q1[$];
  expW_t qW[$];
  int    ordQ[$];
  logic [NW:0] wStage;

  mpadder_modsched_if #(.N(8))  bus8 ();
  mpadder_modsched_if #(.N(NW)) busW ();

  mpadder_modsched #(.N(8), .ADDER_LAT(1)) dut8 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus8)
  );

  mpadder_modsched #(.N(NW), .ADDER_LAT(2)) dutW (
    .clk   (clk),
    .resetn(resetn),
    .bus   (busW)
  );

  // Free-running clock and a cycle counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared adders: registered results, one stage for the 8-bit instance, two for the wide one.
  always @(posedge clk) begin
    bus8.add_result <= bus8.add_sub ? ({1'b0, bus8.add_a} - {1'b0, bus8.add_b})
                                    : ({1'b0, bus8.add_a} + {1'b0, bus8.add_b});
  end

  always @(posedge clk) begin
    wStage          <= busW.add_sub ? ({1'b0, busW.add_a} - {1'b0, busW.add_b})
                                    : ({1'b0, busW.add_a} + {1'b0, busW.add_b});
    busW.add_result <= wStage;
  end

  // Compares one observed value against its expectation and records the outcome.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic checkWide(input string name, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got low128 %h, expected low128 %h", name, got[127:0], exp[127:0]);
    end
  endtask

  // Reference model: plain modular arithmetic on integers.
  function automatic logic [7:0] modRef8(input logic [7:0] a, input logic [7:0] b,
                                         input logic opSub, input logic [7:0] m);
    int ai = int'(a);
    int bi = int'(b);
    int mi = int'(m);
    if (opSub) return 8'((ai - bi + mi) % mi);
    return 8'((ai + bi) % mi);
  endfunction

  function automatic logic [NW-1:0] modRefWide(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                                input logic opSub, input logic [NW-1:0] m);
    logic [NW:0] aa = {1'b0, a};
    logic [NW:0] bb = {1'b0, b};
    logic [NW:0] mm = {1'b0, m};
    logic [NW:0] t;
    if (!opSub) begin
      t = aa + bb;
      if (t >= mm) t = t - mm;
    end else begin
      t = (aa >= bb) ? (aa - bb) : (aa + mm - bb);
    end
    return t[NW-1:0];
  endfunction

  function automatic logic [NW-1:0] randWide();
    logic [NW-1:0] v = '0;
    for (int i = 0; i < 33; i++) v = {v[NW-33:0], 32'($urandom())};
    return v;
  endfunction

  // Issues a request on the 8-bit instance; lat > 0 also checks the done latency.
  task automatic applyStimulus(input int r, input logic opSub, input logic [7:0] a,
                               input logic [7:0] b, input int lat);
    exp8_t e;
    e.res      = modRef8(a, b, opSub, bus8.modulus);
    e.issueCyc = cyc;
    e.lat      = lat;
    if (r == 0) begin
      bus8.op0 = opSub; bus8.a0 = a; bus8.b0 = b; bus8.req0 = 1'b1;
      q0.push_back(e);
    end else begin
      bus8.op1 = opSub; bus8.a1 = a; bus8.b1 = b; bus8.req1 = 1'b1;
      q1.push_back(e);
    end
  endtask

  task automatic applyStimulusWide(input logic opSub, input logic [NW-1:0] a,
                                   input logic [NW-1:0] b, input int lat);
    expW_t e;
    e.res      = modRefWide(a, b, opSub, busW.modulus);
    e.issueCyc = cyc;
    e.lat      = lat;
    busW.op0 = opSub; busW.a0 = a; busW.b0 = b; busW.req0 = 1'b1;
    qW.push_back(e);
  endtask

  // Advances to the next falling edge; a requester drops req when it sees its done.
  task automatic tick();
    @(negedge clk);
    if (bus8.done0) bus8.req0 = 1'b0;
    if (bus8.done1) bus8.req1 = 1'b0;
    if (busW.done0) busW.req0 = 1'b0;
  endtask

  task automatic waitIdle8();
    int n = 0;
    while ((bus8.busy || bus8.req0 || bus8.req1) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle8_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic waitIdleW();
    int n = 0;
    while ((busW.busy || busW.req0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleW_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  // Scoreboard side: pops the oldest expectation of the requester whose done fired.
  task automatic scoreDone8(input int r);
    exp8_t e;
    int    pending = (r == 0) ? q0.size() : q1.size();
    if (pending == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done%0d_unexpected: got a done pulse, expected none pending", r);
      return;
    end
    e = (r == 0) ? q0.pop_front() : q1.pop_front();
    checkOutput($sformatf("result%0d", r), 32'(bus8.result), 32'(e.res));
    checkOutput($sformatf("grant%0d", r), 32'(bus8.grant), 32'(r));
    if (e.lat > 0) checkOutput($sformatf("latency%0d", r), 32'(cyc - e.issueCyc), 32'(e.lat));
    if (ordQ.size() > 0) checkOutput("serve_order", 32'(r), 32'(ordQ.pop_front()));
  endtask

  task automatic scoreDoneW();
    expW_t e;
    if (busW.done1 || qW.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneW_unexpected: got done0=%0d done1=%0d, expected none pending",
               busW.done0, busW.done1);
      return;
    end
    e = qW.pop_front();
    checkWide("resultW", busW.result, e.res);
    checkOutput("grantW", 32'(busW.grant), 32'd0);
    if (e.lat > 0) checkOutput("latencyW", 32'(cyc - e.issueCyc), 32'(e.lat));
  endtask

  // Monitor: runs independently of stimulus, sampling on the falling edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus8.done0) scoreDone8(0);
      if (bus8.done1) scoreDone8(1);
      if (busW.done0 || busW.done1) scoreDoneW();
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NW-1:0] mW;
    logic [NW-1:0] x;
    logic [NW-1:0] y;

    resetn = 1'b1;
    bus8.modulus = 8'd200;
    bus8.req0 = 1'b0; bus8.req1 = 1'b0; bus8.op0 = 1'b0; bus8.op1 = 1'b0;
    bus8.a0 = '0; bus8.b0 = '0; bus8.a1 = '0; bus8.b1 = '0;
    busW.modulus = '0;
    busW.req0 = 1'b0; busW.req1 = 1'b0; busW.op0 = 1'b0; busW.op1 = 1'b0;
    busW.a0 = '0; busW.b0 = '0; busW.a1 = '0; busW.b1 = '0;
    #2 resetn = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy",   32'(bus8.busy),    32'd0);
    checkOutput("rst_done0",  32'(bus8.done0),   32'd0);
    checkOutput("rst_done1",  32'(bus8.done1),   32'd0);
    checkOutput("rst_grant",  32'(bus8.grant),   32'd0);
    checkOutput("rst_result", 32'(bus8.result),  32'd0);
    checkOutput("rst_add_a",  32'(bus8.add_a),   32'd0);
    checkOutput("rst_add_b",  32'(bus8.add_b),   32'd0);
    checkOutput("rst_addsub", 32'(bus8.add_sub), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed single operations from idle.
    bus8.modulus = 8'd200;
    applyStimulus(0, 1'b0, 8'd150, 8'd100, 5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("busy_cycle%0d", i), 32'(bus8.busy), 32'd1);
    end
    waitIdle8();
    applyStimulus(1, 1'b0, 8'd10, 8'd20, 5);
    waitIdle8();
    bus8.modulus = 8'd250;
    applyStimulus(0, 1'b0, 8'd249, 8'd249, 5);
    waitIdle8();
    bus8.modulus = 8'd200;
    applyStimulus(0, 1'b1, 8'd50, 8'd20, 3);
    waitIdle8();
    applyStimulus(1, 1'b1, 8'd20, 8'd50, 5);
    waitIdle8();

    // Arbitration from a fresh reset: req0 wins the first tie, then alternation.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    ordQ.push_back(0);
    ordQ.push_back(1);
    ordQ.push_back(0);
    applyStimulus(0, 1'b0, 8'd150, 8'd100, 5);
    applyStimulus(1, 1'b1, 8'd50, 8'd20, 0);
    for (int n = 0; n < 50 && bus8.req0; n++) tick();
    tick();
    tick();
    checkOutput("busy_while_rereq", 32'(bus8.busy), 32'd1);
    applyStimulus(0, 1'b0, 8'd10, 8'd20, 0);
    waitIdle8();
    ordQ.push_back(1);
    ordQ.push_back(0);
    applyStimulus(0, 1'b0, 8'd199, 8'd199, 0);
    applyStimulus(1, 1'b1, 8'd0, 8'd199, 0);
    waitIdle8();
    checkOutput("order_drained", 32'(ordQ.size()), 32'd0);

    // Reset in the middle of PASS1 aborts silently.
    applyStimulus(1, 1'b0, 8'd100, 8'd120, 0);
    tick();
    checkOutput("pre_abort_busy", 32'(bus8.busy), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("abort_busy",   32'(bus8.busy),    32'd0);
    checkOutput("abort_done1",  32'(bus8.done1),   32'd0);
    checkOutput("abort_grant",  32'(bus8.grant),   32'd0);
    checkOutput("abort_result", 32'(bus8.result),  32'd0);
    checkOutput("abort_add_a",  32'(bus8.add_a),   32'd0);
    checkOutput("abort_addsub", 32'(bus8.add_sub), 32'd0);
    void'(q1.pop_front());
    bus8.req1 = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    applyStimulus(1, 1'b0, 8'd100, 8'd120, 5);
    waitIdle8();

    // Random traffic from both requesters, modulus fixed per batch.
    for (int batch = 0; batch < 3; batch++) begin
      waitIdle8();
      bus8.modulus = 8'($urandom_range(255, 2));
      for (int c = 0; c < 250; c++) begin
        tick();
        if (!bus8.req0 && !bus8.done0 && $urandom_range(2, 0) == 0)
          applyStimulus(0, 1'($urandom_range(1, 0)),
                        8'($urandom_range(int'(bus8.modulus) - 1, 0)),
                        8'($urandom_range(int'(bus8.modulus) - 1, 0)), 0);
        if (!bus8.req1 && !bus8.done1 && $urandom_range(2, 0) == 0)
          applyStimulus(1, 1'($urandom_range(1, 0)),
                        8'($urandom_range(int'(bus8.modulus) - 1, 0)),
                        8'($urandom_range(int'(bus8.modulus) - 1, 0)), 0);
      end
    end
    waitIdle8();

    // Full-width instance with a two-cycle adder.
    mW = randWide() | {1'b1, {(NW-1){1'b0}}};
    busW.modulus = mW;
    x = NW'($urandom_range(1000, 1));
    y = NW'($urandom_range(1000, 1));
    tick();
    applyStimulusWide(1'b0, mW - 1 - x, mW - 1 - y, 7);
    waitIdleW();
    applyStimulusWide(1'b1, randWide() >> 2, mW - 1 - x, 7);
    waitIdleW();
    applyStimulusWide(1'b1, mW - 1 - y, randWide() >> 2, 4);
    waitIdleW();
    applyStimulusWide(1'b0, randWide() >> 1, randWide() >> 1, 7);
    waitIdleW();

    tick();
    checkOutput("pending_left", 32'(q0.size() + q1.size() + qW.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpadder_modsched.md
Name: mpadder_modsched

Overview:
- Scheduler and sequencer that shares one multi-precision adder (the 1027-bit mpadder datapath) between two requesters.
- Each request is a modular add or subtract: result = (a + b) mod M or (a − b) mod M.
- The block arbitrates round-robin, drives the adder operands and subtract control, and performs the conditional modulus correction as a second adder pass.
- It sits between the Montgomery/exponentiation control and the shared adder.

Parameters:
- N, 1027, operand/modulus width; adder result is N+1 bits.
- ADDER_LAT, 1, clock cycles from adder inputs stable to add_result valid (>=1).

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- modulus  in  N  M, static during any operation
- req0 / req1  in  1  request, held high until the matching done pulse
- op0 / op1  in  1  0 = modular add, 1 = modular subtract
- a0, b0 / a1, b1  in  N  operands, stable while req high, each < M
- done0 / done1  out  1  one-cycle completion pulse to requester 0 / 1
- result  out  N  modular result, held until the next done
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the requester being served
- add_a, add_b  out  N  registered adder operands
- add_sub  out  1  registered adder subtract select
- add_result  in  N+1  adder output: a+b with carry in bit N, or a−b two's complement with borrow in bit N

Behaviour:
- Reset (async, resetn=0): state IDLE; done0, done1, busy, grant, add_sub = 0; result, add_a, add_b = 0; RR pointer = 0 (req0 priority).
- Reset mid-operation aborts the operation. No done pulse is issued and no adder result is consumed.
- States: IDLE, PASS1, PASS2, DONE. A wait counter of ADDER_LAT cycles runs in PASS1 and PASS2.
- IDLE
  - If any req is high, grant the requester selected by the RR pointer when both are high, else the single requester. Latch grant.
  - Load add_a=a, add_b=b, add_sub=op. Go to PASS1.
- PASS1: after ADDER_LAT cycles, sample add_result into s (N+1 bits).
  - Add: load add_a=s[N-1:0], add_b=M, add_sub=1. Go to PASS2.
  - Sub, s[N]=0 (no borrow): result=s[N-1:0]. Go to DONE; PASS2 is skipped.
  - Sub, s[N]=1: load add_a=s[N-1:0], add_b=M, add_sub=0. Go to PASS2.
- PASS2: after ADDER_LAT cycles, sample add_result into t.
  - Add: result = t[N-1:0] if s[N]=1 or t[N]=0, else s[N-1:0].
  - Sub: result = t[N-1:0], carry discarded.
  - Go to DONE.
- DONE: pulse done[grant] for one cycle. Toggle the RR pointer to the non-served requester. Next state is IDLE.
- Requester handshake: the requester deasserts req on the edge where its done is high. IDLE therefore never re-serves a completed request.
- Latency, with cycle 0 = IDLE cycle that sees req:
  - add: done at cycle 3+2·ADDER_LAT (5 at LAT=1)
  - sub without borrow: done at cycle 2+ADDER_LAT (3)
  - sub with borrow: done at cycle 3+2·ADDER_LAT (5)
- Simultaneous requests: one is served, the other waits while busy. The pointer guarantees alternation, so there is no starvation.
- A req that drops mid-operation is a protocol violation. The operation still completes and done still pulses.
- A request arriving while busy is ignored until IDLE.
- Changing modulus or operands mid-operation is undefined; no check is performed.

Test Plan:
- N=8, M=200, req0 add 150+100 -> done0 at cycle 5, result=50, busy high cycles 1-4.
- N=8, M=200, req1 add 10+20 -> result=30 (PASS2 borrow keeps s), done1 at cycle 5, grant=1.
- N=8, M=250, add 249+249 (carry out, s[8]=1) -> result=248.
- N=8, M=200, sub 50−20 -> result=30, done at cycle 3, PASS2 skipped. Sub 20−50 -> result=170, done at cycle 5.
- Arbitration, after reset:
  - req0 and req1 both high -> req0 served first, then req1.
  - Both re-requested -> req1 served first.
  - req0 held while busy -> no lost or duplicate done.
- Mid-PASS1 reset:
  - resetn low -> all outputs zero immediately, no done pulse.
  - After release, a fresh request completes normally.
  - Repeat one add at N=1027, ADDER_LAT=2 -> done at cycle 7 with the correct value.
